addr_seq: RTL
=============

Name: addr_seq

Overview:
- Sequencer that produces the 14-bit memory address/control word and the select for the downstream 2:1 address/control mux.
- Drives that mux's in_0 input and its 2-bit sel, and claims the memory bus for a burst of consecutive addresses.
- When idle, it releases the bus (sel = 2'b00) so the other master on in_1 owns memory.

Parameters:
- AW, 12, address field width; bus word width is AW+2 = 14.
- CW, 12, burst-length counter width (max burst 4095 words).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  burst request, sampled only in IDLE.
- base_addr  input  12  first address of burst, latched on accept.
- length  input  12  number of words in burst; 0 = no-op.
- write_mode  input  1  1 = write burst, 0 = read burst; latched on accept.
- stall  input  1  downstream not ready; suppresses issue on that edge.
- seq_bus  output  14  registered word to mux in_0: [11:0] address, [12] mem_en, [13] mem_we.
- bus_sel  output  2  registered mux select: 2'b01 = sequencer owns bus, 2'b00 = released.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at burst end.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - State goes to IDLE.
  - seq_bus=0, bus_sel=2'b00, busy=0, done=0; internal count and latched fields cleared.
  - Reset mid-burst aborts the burst with no done pulse.
- All outputs are registered. Edges are numbered E0 (accept), E1, E2, ...
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 and length!=0 → RUN. Latch base, length and mode; cnt=0. Outputs after E0: bus_sel=01, busy=1, en=0, we=0.
  - start=1 and length==0 → stay IDLE; done=1 for the next cycle only; bus_sel stays 00.
  - start=0 → hold; done=0.
- RUN, at each edge:
  - cnt<len and stall=0: issue word. addr=(base+cnt) mod 4096, en=1, we=mode; cnt++.
  - cnt<len and stall=1: en=0, we=0, address held, cnt unchanged.
  - cnt==len: go to DRAIN; en=0, we=0, address held; bus_sel stays 01.
- DRAIN, next edge: go to IDLE; bus_sel=00, busy=0, done=1 for exactly one cycle; seq_bus=0.
- Timing with no stall and length L:
  - Words appear after E1..EL.
  - Guard cycle after E(L+1).
  - done pulse and bus release after E(L+2).
  - The select leads the first word by one cycle and trails the last word by one cycle, so the mux never switches while en=1.
- start while busy is ignored. No queuing.
- stall has no effect in IDLE or DRAIN.
- Address wrap: 12-bit modulo add, no carry out. For example base=0xFFE, L=3 gives 0xFFE, 0xFFF, 0x000.
- en and we are never both asserted outside RUN. we=1 only together with en=1.

Decomposition:
- Shared package holds:
  - AW=12 and BUS_W=14.
  - Bit-position constants ADDR_LSB=0, EN_BIT=12, WE_BIT=13.
  - Select encodings SEL_SEQ=2'b01 and SEL_EXT=2'b00.
  - State enum {IDLE, RUN, DRAIN}.
- No sub-module is needed. The address adder and counter sit inline in the single module, roughly 150 lines.

Test Plan:
- Reset → all outputs 0. Assert rst mid-burst (after word 2 of an 8-word burst) → next cycle bus_sel=00, seq_bus=0, busy=0, no done.
- start, base=0x010, length=4, write_mode=0, no stall:
  - bus_sel=01 after E0.
  - seq_bus addresses 0x010..0x013 with en=1, we=0 after E1..E4.
  - en=0 after E5.
  - done=1 and bus_sel=00 after E6.
- Same burst in write mode with stall=1 on E2 and E3 → word 1 (0x011) appears after E4 (en=0 between), all 4 words issued once, we=1 on each, done delayed by 2 cycles.
- base=0xFFE, length=3 → addresses 0xFFE, 0xFFF, 0x000.
- start with length=0 → done pulse one cycle later, bus_sel stays 00, busy stays 0.
- start pulsed again during RUN with different base → ignored; original burst completes unchanged; a new start accepted in the cycle after done is honoured.

Source files
------------

// File: rtl/addr_seq_pkg.sv
// Shared constants and state type for the address/control sequencer that
// feeds in_0 of the downstream 2:1 address/control mux.
package addr_seq_pkg;

  localparam int AW       = 12;
  localparam int CW       = 12;
  localparam int BUS_W    = AW + 2;

  localparam int ADDR_LSB = 0;
  localparam int EN_BIT   = 12;
  localparam int WE_BIT   = 13;

  localparam logic [1:0] SEL_SEQ = 2'b01;
  localparam logic [1:0] SEL_EXT = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/addr_seq.sv
// Burst address sequencer: claims the memory bus via the mux select, issues
// consecutive addresses with en/we, then releases the bus and pulses done.
module addr_seq
  import addr_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [CW-1:0]    length,
  input  logic             write_mode,
  input  logic             stall,
  output logic [BUS_W-1:0] seq_bus,
  output logic [1:0]       bus_sel,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  state_e           state_q, state_d;
  logic [AW-1:0]    base_q, base_d;
  logic [CW-1:0]    len_q, len_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [BUS_W-1:0] bus_q, bus_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    bus_d   = bus_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        bus_d  = '0;
        sel_d  = SEL_EXT;
        busy_d = 1'b0;
        if (start) begin
          if (length != '0) begin
            state_d = RUN;
            base_d  = base_addr;
            len_d   = length;
            mode_d  = write_mode;
            cnt_d   = '0;
            sel_d   = SEL_SEQ;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        // Address field holds its last value whenever no word is issued.
        bus_d[EN_BIT] = 1'b0;
        bus_d[WE_BIT] = 1'b0;
        if (cnt_q == len_q) begin
          state_d = DRAIN;
        end else if (!stall) begin
          bus_d[ADDR_LSB +: AW] = base_q + cnt_q;
          bus_d[EN_BIT]         = 1'b1;
          bus_d[WE_BIT]         = mode_q;
          cnt_d                 = cnt_q + 1'b1;
        end
      end

      DRAIN: begin
        state_d = IDLE;
        bus_d   = '0;
        sel_d   = SEL_EXT;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
        bus_d   = '0;
        sel_d   = SEL_EXT;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      bus_q   <= '0;
      sel_q   <= SEL_EXT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      bus_q   <= bus_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign seq_bus   = bus_q;
  assign bus_sel   = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
